spi_master_data_path: RTL and testbench

- SPI initiator for the crypto accelerator's SPI slave data path. Drives one complete frame on sclk/cs_n/mosi[3:0] in single, dual or quad mode, and captures read data from miso[3:0].
- Frame layout, LSB first: addr bits 0-19, status bits 20-23, turnaround bits 24-31, data bits 32-47. In burst mode, further 16-bit data words follow.
- Sits on the host/test side of the link and is controlled by a simple start/done handshake.

---
 rtl/spi_pkg.sv | 64 ++++++
 rtl/spi_sclk_gen.sv | 33 +++
 rtl/spi_master_data_path.sv | 208 ++++++++++++++++++++
 tb/tb_spi_master_data_path.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared encodings, frame layout and lane helpers for the SPI initiator data path.
package spi_pkg;

    localparam logic [1:0] SPI_MODE_ILL = 2'b00;
    localparam logic [1:0] SPI_MODE_1   = 2'b01;
    localparam logic [1:0] SPI_MODE_2   = 2'b10;
    localparam logic [1:0] SPI_MODE_4   = 2'b11;

    localparam int unsigned ADDR_LSB   = 0;
    localparam int unsigned STATUS_LSB = 20;
    localparam int unsigned TURN_LSB   = 24;
    localparam int unsigned DATA_LSB   = 32;
    localparam int unsigned FRAME_BITS = 48;

    localparam int unsigned ST_WRITE = 2;
    localparam int unsigned ST_BURST = 1;

    localparam int unsigned PTR_W = 6;
    localparam int unsigned DIV_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_HOLD
    } state_t;

    function automatic logic [2:0] lane_count(input logic [1:0] mode);
        case (mode)
            SPI_MODE_1: lane_count = 3'd1;
            SPI_MODE_2: lane_count = 3'd2;
            SPI_MODE_4: lane_count = 3'd4;
            default:    lane_count = 3'd1;
        endcase
    endfunction

    // Whole frame as a flat vector; turnaround is zero and read data phases drive zero.
    function automatic logic [FRAME_BITS-1:0] frame_bits(input logic [19:0] addr,
                                                         input logic [3:0]  status,
                                                         input logic [15:0] wdata);
        logic [FRAME_BITS-1:0] f;
        f                    = '0;
        f[ADDR_LSB +: 20]    = addr;
        f[STATUS_LSB +: 4]   = status;
        f[TURN_LSB +: 8]     = 8'h00;
        f[DATA_LSB +: 16]    = status[ST_WRITE] ? wdata : 16'h0000;
        frame_bits           = f;
    endfunction

    // Lane k carries frame bit ptr+k; unused lanes and bits past the frame drive zero.
    function automatic logic [3:0] lane_bits(input logic [FRAME_BITS-1:0] f,
                                             input logic [PTR_W-1:0]      ptr,
                                             input logic [1:0]            mode);
        logic [2:0] n;
        n         = lane_count(mode);
        lane_bits = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < n && (int'(ptr) + k) < int'(FRAME_BITS))
                lane_bits[2'(k)] = f[ptr + PTR_W'(k)];
        end
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period divider: holds sclk for CLK_DIV clk cycles per phase, flags the last cycle of each phase.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic rise,
    output logic sclk,
    output logic half_end_c,
    output logic fall_c
);

    logic [DIV_W-1:0] cnt;

    assign half_end_c = en && (cnt == DIV_W'(CLK_DIV - 1));
    assign fall_c     = sclk && half_end_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else begin
            if (rise || fall_c || !en) cnt <= '0;
            else                       cnt <= cnt + DIV_W'(1);
            if (rise)                  sclk <= 1'b1;
            else if (fall_c || !en)    sclk <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_master_data_path.sv
// SPI initiator: shifts one addr/status/turnaround/data frame (optionally bursting data words)
// in single, dual or quad mode and captures read data from miso.
module spi_master_data_path
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 8,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  spi_mode,
    input  logic [19:0] addr,
    input  logic [3:0]  status,
    input  logic [15:0] wdata,
    input  logic        burst_cont,
    input  logic [3:0]  miso,
    output logic        busy,
    output logic        done,
    output logic        word_done,
    output logic [15:0] rdata_out,
    output logic        rdata_valid,
    output logic        err,
    output logic        sclk,
    output logic        cs_n,
    output logic [3:0]  mosi
);

    state_t                state, state_d;
    logic [DIV_W-1:0]      cnt, cnt_d;
    logic [PTR_W-1:0]      ptr, ptr_d;
    logic [1:0]            mode_q, mode_d;
    logic [19:0]           addr_q, addr_d;
    logic [3:0]            status_q, status_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [15:0]           shreg, shreg_d;
    logic [15:0]           rdata_d;
    logic                  busy_d, done_d, word_done_d, rdata_valid_d, err_d, cs_n_d;
    logic [3:0]            mosi_d;

    logic                  rise_c, half_end_c, fall_c, sclk_en_c;
    logic [2:0]            nl_c;
    logic [PTR_W-1:0]      ptr_nx_c;
    logic [FRAME_BITS-1:0] frame_c;
    logic                  is_read_c;

    assign sclk_en_c = (state == S_SHIFT_HI) || (state == S_SHIFT_LO);
    assign nl_c      = lane_count(mode_q);
    assign ptr_nx_c  = ptr + PTR_W'(nl_c);
    assign frame_c   = frame_bits(addr_q, status_q, wdata_q);
    assign is_read_c = !status_q[ST_WRITE];

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (sclk_en_c),
        .rise       (rise_c),
        .sclk       (sclk),
        .half_end_c (half_end_c),
        .fall_c     (fall_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        ptr_d         = ptr;
        mode_d        = mode_q;
        addr_d        = addr_q;
        status_d      = status_q;
        wdata_d       = wdata_q;
        shreg_d       = shreg;
        rdata_d       = rdata_out;
        busy_d        = busy;
        cs_n_d        = cs_n;
        mosi_d        = mosi;
        done_d        = 1'b0;
        word_done_d   = 1'b0;
        rdata_valid_d = 1'b0;
        err_d         = 1'b0;
        rise_c        = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (spi_mode == SPI_MODE_ILL) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d   = spi_mode;
                        addr_d   = addr;
                        status_d = status;
                        wdata_d  = wdata;
                        busy_d   = 1'b1;
                        cs_n_d   = 1'b0;
                        ptr_d    = '0;
                        cnt_d    = '0;
                        mosi_d   = lane_bits(frame_bits(addr, status, wdata), '0, spi_mode);
                        state_d  = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (cnt == DIV_W'(CS_SETUP - 1)) begin
                    rise_c  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SHIFT_HI;
                end else begin
                    cnt_d = cnt + DIV_W'(1);
                end
            end
            S_SHIFT_HI: begin
                if (fall_c) begin
                    state_d = S_SHIFT_LO;
                    if (ptr_nx_c == PTR_W'(FRAME_BITS)) begin
                        word_done_d = 1'b1;
                        wdata_d     = wdata;
                        if (is_read_c) begin
                            rdata_valid_d = 1'b1;
                            rdata_d       = shreg;
                        end
                        if (status_q[ST_BURST] && burst_cont) begin
                            ptr_d  = PTR_W'(DATA_LSB);
                            mosi_d = lane_bits(frame_bits(addr_q, status_q, wdata),
                                               PTR_W'(DATA_LSB), mode_q);
                        end else begin
                            ptr_d  = PTR_W'(FRAME_BITS);
                            mosi_d = '0;
                        end
                    end else begin
                        ptr_d  = ptr_nx_c;
                        mosi_d = lane_bits(frame_c, ptr_nx_c, mode_q);
                    end
                end
            end
            S_SHIFT_LO: begin
                if (half_end_c) begin
                    if (ptr == PTR_W'(FRAME_BITS)) begin
                        cnt_d   = '0;
                        state_d = S_HOLD;
                    end else begin
                        rise_c  = 1'b1;
                        state_d = S_SHIFT_HI;
                    end
                end
            end
            S_HOLD: begin
                if (cnt == DIV_W'(CS_HOLD - 1)) begin
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    mosi_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt + DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Read data is sampled on the clk edge that raises sclk for the current lane bits
        if (rise_c && is_read_c && ptr >= PTR_W'(DATA_LSB) && ptr < PTR_W'(FRAME_BITS)) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < nl_c)
                    shreg_d[4'(ptr - PTR_W'(DATA_LSB)) + 4'(k)] = miso[2'(k)];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ptr         <= '0;
            mode_q      <= '0;
            addr_q      <= '0;
            status_q    <= '0;
            wdata_q     <= '0;
            shreg       <= '0;
            rdata_out   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            word_done   <= 1'b0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
            cs_n        <= 1'b1;
            mosi        <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            ptr         <= ptr_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            status_q    <= status_d;
            wdata_q     <= wdata_d;
            shreg       <= shreg_d;
            rdata_out   <= rdata_d;
            busy        <= busy_d;
            done        <= done_d;
            word_done   <= word_done_d;
            rdata_valid <= rdata_valid_d;
            err         <= err_d;
            cs_n        <= cs_n_d;
            mosi        <= mosi_d;
        end
    end

endmodule

// File: tb/tb_spi_master_data_path.sv
// Bench for spi_master_data_path: loopback slave model plus directed and randomized frames.
module tb_spi_master_data_path;

    localparam int unsigned CLK_DIV  = 8;
    localparam int unsigned CS_SETUP = 4;
    localparam int unsigned CS_HOLD  = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  spi_mode = 2'b01;
    logic [19:0] addr = '0;
    logic [3:0]  status = '0;
    logic [15:0] wdata = '0;
    logic        burst_cont = 1'b0;
    logic [3:0]  miso;
    logic        busy, done, word_done, rdata_valid, err, sclk, cs_n;
    logic [15:0] rdata_out;
    logic [3:0]  mosi;

    int n_checks = 0;
    int n_fail   = 0;

    int          cur_lanes = 1;
    logic [15:0] wr_words [4];
    logic [15:0] rd_words [4];
    logic [127:0] rx_vec;
    int          rx_n = 0;
    int          rise_cnt = 0;
    int          m_pos, m_w, m_b;

    always #5 clk = ~clk;

    spi_master_data_path #(
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .spi_mode    (spi_mode),
        .addr        (addr),
        .status      (status),
        .wdata       (wdata),
        .burst_cont  (burst_cont),
        .miso        (miso),
        .busy        (busy),
        .done        (done),
        .word_done   (word_done),
        .rdata_out   (rdata_out),
        .rdata_valid (rdata_valid),
        .err         (err),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi)
    );

    // Slave: collects mosi lanes on each rising sclk edge, restarts when cs_n falls
    always @(posedge sclk or negedge cs_n) begin
        if (!sclk) begin
            rx_vec   = '0;
            rx_n     = 0;
            rise_cnt = 0;
        end else if (!cs_n) begin
            for (int k = 0; k < cur_lanes; k++)
                if (rx_n + k < 128) rx_vec[7'(rx_n + k)] = mosi[2'(k)];
            rx_n     = rx_n + cur_lanes;
            rise_cnt = rise_cnt + 1;
        end
    end

    // Slave read data: the bits for the next rising edge, word by word after the turnaround
    always_comb begin
        miso  = '0;
        m_pos = rise_cnt * cur_lanes;
        m_w   = 0;
        m_b   = 0;
        if (m_pos >= 32) begin
            m_w = (m_pos - 32) / 16;
            m_b = (m_pos - 32) % 16;
            for (int k = 0; k < cur_lanes; k++)
                if (m_w < 4 && m_b + k < 16) miso[2'(k)] = rd_words[2'(m_w)][4'(m_b + k)];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs >= exp - 1 && obs <= exp + 1) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +-1", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input string name, input logic [1:0] mode, input logic [19:0] a,
                             input logic [3:0] st, input int nwords, input bit inject,
                             input int abort_rise);
        int lanes, exp_n, exp_rises, exp_low;
        int rises, low, n_done, n_wd, n_rv, n_rv_bad, words_seen, post, inj;
        bit prev_sclk, seen_done, aborted;
        logic [127:0] exp_vec;
        logic [15:0] caps [4];
        lanes = (mode == 2'b11) ? 4 : (mode == 2'b10) ? 2 : 1;
        cur_lanes = lanes;
        exp_vec = '0;
        exp_n = 32 + 16 * nwords;
        for (int i = 0; i < 20; i++) exp_vec[7'(i)] = a[5'(i)];
        for (int i = 0; i < 4; i++)  exp_vec[7'(20 + i)] = st[2'(i)];
        for (int w = 0; w < nwords; w++)
            for (int i = 0; i < 16; i++)
                exp_vec[7'(32 + 16 * w + i)] = st[2] ? wr_words[2'(w)][4'(i)] : 1'b0;
        exp_rises = exp_n / lanes;
        exp_low   = int'(CS_SETUP) + exp_rises * 2 * int'(CLK_DIV) + int'(CS_HOLD);
        rises = 0; low = 0; n_done = 0; n_wd = 0; n_rv = 0; n_rv_bad = 0;
        words_seen = 0; post = 0; inj = 0;
        prev_sclk = 1'b0; seen_done = 1'b0; aborted = 1'b0;
        for (int i = 0; i < 4; i++) caps[i] = '0;

        @(negedge clk);
        spi_mode   = mode;
        addr       = a;
        status     = st;
        wdata      = wr_words[0];
        burst_cont = st[1] ? (nwords > 1) : 1'($urandom);
        start      = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        addr     = 20'($urandom);
        status   = 4'($urandom);
        spi_mode = 2'($urandom);
        wdata    = wr_words[1];
        chk({name, " busy after start"}, 128'(busy), 128'(1'b1));
        chk({name, " cs_n after start"}, 128'(cs_n), 128'(1'b0));

        for (int cyc = 0; cyc < 20000 && post < 4; cyc++) begin
            if (!cs_n) low++;
            if (sclk && !prev_sclk) rises++;
            prev_sclk = sclk;
            if (rdata_valid) begin
                if (n_rv < 4) caps[2'(n_rv)] = rdata_out;
                n_rv++;
                if (!word_done) n_rv_bad++;
            end
            if (word_done) begin
                n_wd++;
                words_seen++;
                wdata      = (words_seen + 1 < 4) ? wr_words[2'(words_seen + 1)] : 16'($urandom);
                burst_cont = st[1] ? (words_seen < nwords - 1) : 1'($urandom);
            end
            if (inject) begin
                if (inj == 1) begin
                    start = 1'b0;
                    inj   = 2;
                end else if (inj == 0 && rises == 32 / lanes + 1) begin
                    start    = 1'b1;
                    spi_mode = 2'b01;
                    addr     = ~a;
                    status   = st ^ 4'b0100;
                    inj      = 1;
                end
            end
            if (done) begin
                n_done++;
                if (!seen_done) begin
                    chk({name, " cs_n at done"}, 128'(cs_n), 128'(1'b1));
                    chk({name, " busy at done"}, 128'(busy), 128'(1'b0));
                end
                seen_done = 1'b1;
            end
            if (seen_done) post++;
            if (abort_rise > 0 && rises == abort_rise) begin
                reset_n = 1'b0;
                #1;
                chk({name, " sclk in reset"}, 128'(sclk), 128'(1'b0));
                chk({name, " cs_n in reset"}, 128'(cs_n), 128'(1'b1));
                chk({name, " mosi in reset"}, 128'(mosi), 128'(4'h0));
                chk({name, " busy in reset"}, 128'(busy), 128'(1'b0));
                @(negedge clk);
                reset_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (aborted) return;

        chk({name, " completed"}, 128'(seen_done), 128'(1'b1));
        chk({name, " done pulses"}, 128'(n_done), 128'(1));
        chk({name, " sclk rises"}, 128'(rises), 128'(exp_rises));
        chk_near({name, " cs_n low cycles"}, low, exp_low);
        chk({name, " word_done pulses"}, 128'(n_wd), 128'(nwords));
        chk({name, " rdata_valid pulses"}, 128'(n_rv), 128'(st[2] ? 0 : nwords));
        chk({name, " rdata_valid without word_done"}, 128'(n_rv_bad), 128'(0));
        chk({name, " slave bit count"}, 128'(rx_n), 128'(exp_n));
        chk({name, " slave bits"}, rx_vec, exp_vec);
        if (!st[2]) begin
            for (int w = 0; w < nwords; w++)
                chk({name, " read word"}, 128'(caps[2'(w)]), 128'(rd_words[2'(w)]));
            chk({name, " rdata_out held"}, 128'(rdata_out), 128'(rd_words[2'(nwords - 1)]));
        end
    endtask

    initial begin
        logic [1:0] rm;
        logic [3:0] rs;
        int         rn;
        for (int i = 0; i < 4; i++) begin
            wr_words[i] = 16'($urandom);
            rd_words[i] = 16'($urandom);
        end

        repeat (3) @(negedge clk);
        chk("reset sclk", 128'(sclk), 128'(1'b0));
        chk("reset cs_n", 128'(cs_n), 128'(1'b1));
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle outputs", 128'({busy, done, word_done, rdata_valid, err, sclk, cs_n, mosi}),
            128'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0}));
        chk("idle rdata_out", 128'(rdata_out), 128'(16'h0000));

        wr_words[0] = 16'h1234;
        run_frame("single write", 2'b01, 20'hA5F3C, 4'b0100, 1, 1'b0, 0);

        rd_words[0] = 16'hBEEF;
        run_frame("quad read", 2'b11, 20'h0F00D, 4'b0000, 1, 1'b0, 0);

        wr_words[0] = 16'h0001;
        wr_words[1] = 16'h0002;
        run_frame("dual burst write", 2'b10, 20'h12345, 4'b0110, 2, 1'b0, 0);

        @(negedge clk);
        spi_mode = 2'b00;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("illegal err pulse", 128'(err), 128'(1'b1));
        chk("illegal busy", 128'(busy), 128'(1'b0));
        chk("illegal cs_n", 128'(cs_n), 128'(1'b1));
        chk("illegal sclk", 128'(sclk), 128'(1'b0));
        @(negedge clk);
        chk("illegal err one cycle", 128'(err), 128'(1'b0));
        repeat (20) @(negedge clk);
        chk("illegal cs_n later", 128'({cs_n, sclk, busy}), 128'({1'b1, 1'b0, 1'b0}));

        wr_words[0] = 16'hC0DE;
        run_frame("reset mid-frame", 2'b01, 20'hA5F3C, 4'b0100, 1, 1'b0, 11);
        @(negedge clk);
        chk("after reset rdata_out", 128'(rdata_out), 128'(16'h0000));
        wr_words[0] = 16'h5A5A;
        run_frame("frame after reset", 2'b01, 20'h3C3C3, 4'b0100, 1, 1'b0, 0);

        wr_words[0] = 16'h9ABC;
        run_frame("start while busy", 2'b10, 20'h55AA5, 4'b0100, 1, 1'b1, 0);

        rd_words[0] = 16'h1357;
        rd_words[1] = 16'h2468;
        rd_words[2] = 16'hFACE;
        run_frame("quad burst read", 2'b11, 20'h00001, 4'b0010, 3, 1'b0, 0);

        for (int t = 0; t < 8; t++) begin
            rm = 2'($urandom_range(1, 3));
            rs = 4'($urandom);
            rn = rs[1] ? int'($urandom_range(1, 3)) : 1;
            for (int i = 0; i < 4; i++) begin
                wr_words[i] = 16'($urandom);
                rd_words[i] = 16'($urandom);
            end
            run_frame("random frame", rm, 20'($urandom), rs, rn, 1'b0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
